secondary_buffer: RTL and testbench
===================================

SECONDARY_BUFFER -- requirements
Module: secondary_buffer

Interface
REQ-001 SHALL have parameter P_N_CHAN, default 24, number of waveform-buffer channels.
REQ-002 SHALL have parameter P_WVB_DATA_WIDTH, default 170, waveform-buffer word width (even).
REQ-003 SHALL have parameter P_WVB_HDR_WIDTH, default 108, waveform-buffer header width.
REQ-004 SHALL have parameter P_BUF_ADR_WIDTH, default 12, data store depth 2^P_BUF_ADR_WIDTH words.
REQ-005 SHALL have parameter P_HDR_ADR_WIDTH, default 6, header store depth 2^P_HDR_ADR_WIDTH entries.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port en, input, 1, enables draining of the waveform buffers.
REQ-009 SHALL have port wvb_hdr_empty, input, P_N_CHAN, per-channel header FIFO empty.
REQ-010 SHALL have port wvb_hdr_data, input, P_N_CHAN*P_WVB_HDR_WIDTH, per-channel show-ahead header; channel k at slice k.
REQ-011 SHALL have port wvb_data, input, P_N_CHAN*P_WVB_DATA_WIDTH, per-channel data word; channel k at slice k.
REQ-012 SHALL have ports wvb_hdr_rdreq, wvb_rdreq, wvb_rddone, output, P_N_CHAN each, one-hot per-channel strobes.
REQ-013 SHALL have port buf_data_out, output, P_WVB_DATA_WIDTH/2 (85), data store read word.
REQ-014 SHALL have port hdr_data_out, output, P_WVB_HDR_WIDTH+5 (113), {channel[4:0], header}, show-ahead.
REQ-015 SHALL have port buf_hdr_empty, output, 1, header store empty.
REQ-016 SHALL have port n_wvf_in_buf, output, 16, waveforms held.
REQ-017 SHALL have port buf_wds_used, output, 16, data store words occupied.
REQ-018 SHALL have ports buf_rdreq, buf_hdr_rdreq, buf_rddone, input, 1 each, reader strobes.

Function
REQ-019 SHALL run FSM IDLE -> HDR -> XFER -> DONE -> IDLE; the scan pointer advances round-robin 0..P_N_CHAN-1, wrapping.
REQ-020 In IDLE, SHALL start a transfer only if en=1, wvb_hdr_empty[ptr]=0, header store not full, and free data words >= 2*2^9; otherwise advance ptr by one per cycle.
REQ-021 HDR: SHALL latch wvb_hdr_data[ptr] and ptr, and pulse wvb_hdr_rdreq[ptr] for exactly one cycle.
REQ-022 XFER: SHALL pulse wvb_rdreq[ptr] once per word; word is valid one cycle after the strobe; the next strobe follows two cycles later.
REQ-023 Each wvb word SHALL be written as two store words, bits [169:85] first, then [84:0].
REQ-024 The word with bit P_WVB_DATA_WIDTH-1 (end-of-waveform) set SHALL end XFER after both halves are written.
REQ-025 DONE: SHALL pulse wvb_rddone[ptr] one cycle, push {ptr[4:0], latched header}, increment n_wvf_in_buf, advance ptr.
REQ-026 en falling mid-transfer SHALL NOT abort; the transfer completes, then the FSM idles.
REQ-027 Reader: buf_hdr_rdreq SHALL pop the header store; buf_rdreq SHALL advance the read pointer with buf_data_out valid the next cycle; buf_rddone SHALL decrement n_wvf_in_buf.
REQ-028 buf_wds_used SHALL equal write minus read pointer modulo depth plus full handling; simultaneous write and read SHALL leave it unchanged.
REQ-029 buf_rdreq with the store empty, buf_hdr_rdreq with buf_hdr_empty=1, and buf_rddone with n_wvf_in_buf=0 SHALL be ignored.
REQ-030 Simultaneous DONE increment and buf_rddone SHALL leave n_wvf_in_buf unchanged.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, ptr=0, all strobes 0, n_wvf_in_buf=0, buf_wds_used=0, buf_hdr_empty=1, buf_data_out=0.
REQ-032 Reset mid-transfer SHALL discard partial data without asserting wvb_rddone.

Configuration
REQ-033 With SCDB_CHAN_TAG_EN defined, hdr_data_out[112:108] SHALL carry the source channel; without it, these bits SHALL read 0.

Verification
REQ-034 en=0, two channel-0 waveforms pending -> no wvb strobes, n_wvf_in_buf=0, buf_hdr_empty=1.
REQ-035 en raised -> channel 0 drained: 2 hdr_rdreq and 2 rddone pulses on bit 0 only, n_wvf_in_buf=2, buf_wds_used=2x wvb words.
REQ-036 Channels 0 and 5 pending -> transfers in order 0 then 5, header tags 0 and 5.
REQ-037 Reader pops a header, reads all words, and pulses buf_rddone -> n_wvf_in_buf decrements by 1 and buf_wds_used decreases by the words read; data matches halves in order.
REQ-038 rst_n low mid-XFER -> all outputs at reset values immediately, no rddone pulse.

Source files
------------

// File: rtl/secondary_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | secondary_buffer                                                            |
// | Drains per-channel waveform buffers round-robin into a shared data store   |
// | (two half-words per source word) and a show-ahead header store.            |
// | Optional: SCDB_CHAN_TAG_EN tags stored headers with the source channel.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module secondary_buffer #(
    parameter int P_N_CHAN         = 24,
    parameter int P_WVB_DATA_WIDTH = 170,
    parameter int P_WVB_HDR_WIDTH  = 108,
    parameter int P_BUF_ADR_WIDTH  = 12,
    parameter int P_HDR_ADR_WIDTH  = 6
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    input  logic [P_N_CHAN-1:0]                   wvb_hdr_empty,
    input  logic [P_N_CHAN*P_WVB_HDR_WIDTH-1:0]   wvb_hdr_data,
    input  logic [P_N_CHAN*P_WVB_DATA_WIDTH-1:0]  wvb_data,
    output logic [P_N_CHAN-1:0]                   wvb_hdr_rdreq,
    output logic [P_N_CHAN-1:0]                   wvb_rdreq,
    output logic [P_N_CHAN-1:0]                   wvb_rddone,
    output logic [P_WVB_DATA_WIDTH/2-1:0]         buf_data_out,
    output logic [P_WVB_HDR_WIDTH+4:0]            hdr_data_out,
    output logic                                  buf_hdr_empty,
    output logic [15:0]                           n_wvf_in_buf,
    output logic [15:0]                           buf_wds_used,
    input  logic                                  buf_rdreq,
    input  logic                                  buf_hdr_rdreq,
    input  logic                                  buf_rddone
);

    localparam int HALF_W       = P_WVB_DATA_WIDTH / 2;
    localparam int HDR_OUT_W    = P_WVB_HDR_WIDTH + 5;
    localparam int PTR_W        = (P_N_CHAN > 1) ? $clog2(P_N_CHAN) : 1;
    localparam int BUF_DEPTH    = 1 << P_BUF_ADR_WIDTH;
    localparam int HDR_DEPTH    = 1 << P_HDR_ADR_WIDTH;
    localparam int XFER_RESERVE = 2 * (1 << 9);
    localparam logic [PTR_W-1:0] LAST_CHAN = PTR_W'(P_N_CHAN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [PTR_W-1:0]                r_ptr;
    logic [PTR_W-1:0]                r_chan;
    logic [P_WVB_HDR_WIDTH-1:0]      r_hdr;
    logic                            r_phase;
    logic                            r_lo_pend;
    logic                            r_eop_pend;
    logic [HALF_W-1:0]               r_lo;

    logic [HALF_W-1:0]               r_buf_mem [BUF_DEPTH];
    logic [P_BUF_ADR_WIDTH-1:0]      r_wr_adr;
    logic [P_BUF_ADR_WIDTH-1:0]      r_rd_adr;
    logic [P_BUF_ADR_WIDTH:0]        r_wds_used;

    logic [HDR_OUT_W-1:0]            r_hdr_mem [HDR_DEPTH];
    logic [P_HDR_ADR_WIDTH-1:0]      r_hdr_wr_adr;
    logic [P_HDR_ADR_WIDTH-1:0]      r_hdr_rd_adr;
    logic [P_HDR_ADR_WIDTH:0]        r_hdr_cnt;
    logic [15:0]                     r_n_wvf;

    logic [P_WVB_DATA_WIDTH-1:0]     w_word;
    logic [P_N_CHAN-1:0]             w_sel;
    logic [4:0]                      w_tag;
    logic                            w_hdr_full;
    logic                            w_space_ok;
    logic                            w_start;
    logic                            w_ptr_adv;
    logic                            w_hdr_rd;
    logic                            w_wvb_rd;
    logic                            w_done;
    logic                            w_wr_en;
    logic [HALF_W-1:0]               w_wr_data;
    logic                            w_rd_ok;
    logic                            w_hdr_pop;
    logic                            w_wvf_dec;

`ifdef SCDB_CHAN_TAG_EN
    assign w_tag = 5'(r_chan);
`else
    assign w_tag = 5'd0;
`endif

    assign w_word     = wvb_data[int'(r_chan)*P_WVB_DATA_WIDTH +: P_WVB_DATA_WIDTH];
    assign w_sel      = P_N_CHAN'(1) << r_ptr;
    assign w_hdr_full = (r_hdr_cnt == (P_HDR_ADR_WIDTH+1)'(HDR_DEPTH));
    // A transfer only starts with room for a maximum-length waveform.
    assign w_space_ok = (32'(r_wds_used) <= 32'(BUF_DEPTH - XFER_RESERVE));
    assign w_start    = en && !wvb_hdr_empty[r_ptr] && !w_hdr_full && w_space_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_adv   = 1'b0;
        w_hdr_rd    = 1'b0;
        w_wvb_rd    = 1'b0;
        w_done      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_HDR;
                end else begin
                    w_ptr_adv = 1'b1;
                end
            end
            ST_HDR: begin
                w_hdr_rd    = 1'b1;
                w_state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (!r_phase) begin
                    // Low half of the previous word goes out while the next word is requested.
                    w_wr_en = r_lo_pend;
                    if (r_eop_pend) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_wvb_rd = 1'b1;
                    end
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_word[P_WVB_DATA_WIDTH-1 -: HALF_W];
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_ptr_adv   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign wvb_hdr_rdreq = w_hdr_rd ? w_sel : '0;
    assign wvb_rdreq     = w_wvb_rd ? w_sel : '0;
    assign wvb_rddone    = w_done   ? w_sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_chan     <= '0;
            r_hdr      <= '0;
            r_phase    <= 1'b0;
            r_lo_pend  <= 1'b0;
            r_eop_pend <= 1'b0;
            r_lo       <= '0;
        end else begin
            if (w_ptr_adv) begin
                r_ptr <= (r_ptr == LAST_CHAN) ? '0 : r_ptr + 1'b1;
            end
            case (r_state)
                ST_HDR: begin
                    r_hdr      <= wvb_hdr_data[int'(r_ptr)*P_WVB_HDR_WIDTH +: P_WVB_HDR_WIDTH];
                    r_chan     <= r_ptr;
                    r_phase    <= 1'b0;
                    r_lo_pend  <= 1'b0;
                    r_eop_pend <= 1'b0;
                end
                ST_XFER: begin
                    if (r_phase) begin
                        r_phase    <= 1'b0;
                        r_lo       <= w_word[HALF_W-1:0];
                        r_lo_pend  <= 1'b1;
                        r_eop_pend <= w_word[P_WVB_DATA_WIDTH-1];
                    end else begin
                        r_lo_pend <= 1'b0;
                        r_phase   <= !r_eop_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_rd_ok = buf_rdreq && (r_wds_used != '0);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf_mem[r_wr_adr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_adr     <= '0;
            r_rd_adr     <= '0;
            r_wds_used   <= '0;
            buf_data_out <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_adr <= r_wr_adr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_adr     <= r_rd_adr + 1'b1;
                buf_data_out <= r_buf_mem[r_rd_adr];
            end
            case ({w_wr_en, w_rd_ok})
                2'b10:   r_wds_used <= r_wds_used + 1'b1;
                2'b01:   r_wds_used <= r_wds_used - 1'b1;
                default: r_wds_used <= r_wds_used;
            endcase
        end
    end

    assign w_hdr_pop = buf_hdr_rdreq && (r_hdr_cnt != '0);

    always_ff @(posedge clk) begin
        if (w_done) begin
            r_hdr_mem[r_hdr_wr_adr] <= {w_tag, r_hdr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_wr_adr <= '0;
            r_hdr_rd_adr <= '0;
            r_hdr_cnt    <= '0;
        end else begin
            if (w_done) begin
                r_hdr_wr_adr <= r_hdr_wr_adr + 1'b1;
            end
            if (w_hdr_pop) begin
                r_hdr_rd_adr <= r_hdr_rd_adr + 1'b1;
            end
            case ({w_done, w_hdr_pop})
                2'b10:   r_hdr_cnt <= r_hdr_cnt + 1'b1;
                2'b01:   r_hdr_cnt <= r_hdr_cnt - 1'b1;
                default: r_hdr_cnt <= r_hdr_cnt;
            endcase
        end
    end

    assign w_wvf_dec = buf_rddone && (r_n_wvf != 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_wvf <= 16'd0;
        end else begin
            case ({w_done, w_wvf_dec})
                2'b10:   r_n_wvf <= r_n_wvf + 16'd1;
                2'b01:   r_n_wvf <= r_n_wvf - 16'd1;
                default: r_n_wvf <= r_n_wvf;
            endcase
        end
    end

    assign hdr_data_out  = r_hdr_mem[r_hdr_rd_adr];
    assign buf_hdr_empty = (r_hdr_cnt == '0);
    assign n_wvf_in_buf  = r_n_wvf;
    assign buf_wds_used  = 16'(r_wds_used);

endmodule
`default_nettype wire

// File: tb/tb_secondary_buffer.sv
`default_nettype none
// tb_secondary_buffer: scoreboard bench for secondary_buffer with a behavioural
// model of the channel 0 and channel 5 waveform buffers.
module tb_secondary_buffer;

    localparam int NC   = 24;
    localparam int DW   = 170;
    localparam int HW   = 108;
    localparam int HALF = 85;
    localparam int HOW  = 113;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NC-1:0]     wvb_hdr_empty = '1;
    logic [NC*HW-1:0]  wvb_hdr_data = '0;
    logic [NC*DW-1:0]  wvb_data = '0;
    logic [NC-1:0]     wvb_hdr_rdreq, wvb_rdreq, wvb_rddone;
    logic [HALF-1:0]   buf_data_out;
    logic [HOW-1:0]    hdr_data_out;
    logic              buf_hdr_empty;
    logic [15:0]       n_wvf_in_buf, buf_wds_used;
    logic              buf_rdreq = 1'b0, buf_hdr_rdreq = 1'b0, buf_rddone = 1'b0;

    secondary_buffer dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .wvb_hdr_empty(wvb_hdr_empty), .wvb_hdr_data(wvb_hdr_data), .wvb_data(wvb_data),
        .wvb_hdr_rdreq(wvb_hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
        .buf_data_out(buf_data_out), .hdr_data_out(hdr_data_out),
        .buf_hdr_empty(buf_hdr_empty), .n_wvf_in_buf(n_wvf_in_buf), .buf_wds_used(buf_wds_used),
        .buf_rdreq(buf_rdreq), .buf_hdr_rdreq(buf_hdr_rdreq), .buf_rddone(buf_rddone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [HW-1:0]   hq0[$], hq5[$];
    logic [DW-1:0]   dq0[$], dq5[$];
    logic [HOW-1:0]  exp_hdr[$];
    logic [HALF-1:0] exp_data[$];
    int              exp_len[$];
    int              done_order[$];
    int              hdr_cnt[NC];
    int              rd_cnt[NC];
    int              done_cnt[NC];

    // Waveform-buffer model: show-ahead header FIFO, registered data FIFO.
    always @(posedge clk) begin
        for (int k = 0; k < NC; k++) begin
            if (wvb_hdr_rdreq[k]) hdr_cnt[k]++;
            if (wvb_rdreq[k])     rd_cnt[k]++;
            if (wvb_rddone[k]) begin
                done_cnt[k]++;
                done_order.push_back(k);
            end
        end
        if (wvb_hdr_rdreq[0] && hq0.size() > 0) void'(hq0.pop_front());
        if (wvb_hdr_rdreq[5] && hq5.size() > 0) void'(hq5.pop_front());
        if (wvb_rdreq[0]) wvb_data[0*DW +: DW] <= (dq0.size() > 0) ? dq0.pop_front() : '0;
        if (wvb_rdreq[5]) wvb_data[5*DW +: DW] <= (dq5.size() > 0) ? dq5.pop_front() : '0;
        wvb_hdr_empty[0]         <= (hq0.size() == 0);
        wvb_hdr_empty[5]         <= (hq5.size() == 0);
        wvb_hdr_data[0*HW +: HW] <= (hq0.size() > 0) ? hq0[0] : '0;
        wvb_hdr_data[5*HW +: HW] <= (hq5.size() > 0) ? hq5[0] : '0;
    end

    task automatic refresh();
        wvb_hdr_empty[0]         = (hq0.size() == 0);
        wvb_hdr_empty[5]         = (hq5.size() == 0);
        wvb_hdr_data[0*HW +: HW] = (hq0.size() > 0) ? hq0[0] : '0;
        wvb_hdr_data[5*HW +: HW] = (hq5.size() > 0) ? hq5[0] : '0;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NC; k++) begin
            hdr_cnt[k]  = 0;
            rd_cnt[k]   = 0;
            done_cnt[k] = 0;
        end
        done_order.delete();
    endtask

    function automatic int strobes_except(input int a, input int b);
        int s = 0;
        for (int k = 0; k < NC; k++)
            if (k != a && k != b) s += hdr_cnt[k] + rd_cnt[k] + done_cnt[k];
        return s;
    endfunction

    // Loads one waveform into the channel model and pushes its expected store image.
    task automatic load_wvf(input int ch, input int nwords);
        logic [127:0]    hr;
        logic [191:0]    wr;
        logic [DW-1:0]   w;
        logic [4:0]      tag;
`ifdef SCDB_CHAN_TAG_EN
        tag = 5'(ch);
`else
        tag = 5'd0;
`endif
        hr = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (ch == 0) hq0.push_back(hr[HW-1:0]); else hq5.push_back(hr[HW-1:0]);
        exp_hdr.push_back({tag, hr[HW-1:0]});
        exp_len.push_back(nwords);
        for (int i = 0; i < nwords; i++) begin
            wr = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            w = wr[DW-1:0];
            w[DW-1] = (i == nwords - 1);
            if (ch == 0) dq0.push_back(w); else dq5.push_back(w);
            exp_data.push_back(w[DW-1:HALF]);
            exp_data.push_back(w[HALF-1:0]);
        end
        refresh();
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        hq0.delete(); hq5.delete(); dq0.delete(); dq5.delete();
        exp_hdr.delete(); exp_data.delete(); exp_len.delete();
        refresh();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_nwvf(input int target, input int budget);
        int c = 0;
        while (n_wvf_in_buf != 16'(target) && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (n_wvf_in_buf !== 16'(target)) begin
            errors++;
            $display("FAIL wait_nwvf: n_wvf_in_buf=%0d required %0d after %0d cycles", n_wvf_in_buf, target, c);
        end
    endtask

    task automatic read_wvf(input bit check_cnt);
        logic [HOW-1:0]  eh;
        logic [HALF-1:0] ed;
        logic [15:0]     n0, u0;
        int              len;
        checks++;
        if (exp_hdr.size() == 0 || exp_len.size() == 0) begin
            errors++;
            $display("FAIL read_wvf: scoreboard empty, nothing expected to read");
            return;
        end
        @(negedge clk);
        eh = exp_hdr.pop_front();
        len = exp_len.pop_front();
        n0 = n_wvf_in_buf;
        u0 = buf_wds_used;
        checks++;
        if (buf_hdr_empty !== 1'b0) begin
            errors++;
            $display("FAIL read_hdr_empty: got %b required 0", buf_hdr_empty);
        end
        checks++;
        if (hdr_data_out !== eh) begin
            errors++;
            $display("FAIL read_hdr: got %h required %h", hdr_data_out, eh);
        end
        buf_hdr_rdreq = 1'b1;
        @(negedge clk);
        buf_hdr_rdreq = 1'b0;
        buf_rdreq = 1'b1;
        for (int i = 0; i < 2 * len; i++) begin
            @(negedge clk);
            if (i == 2 * len - 1) buf_rdreq = 1'b0;
            ed = exp_data.pop_front();
            checks++;
            if (buf_data_out !== ed) begin
                errors++;
                $display("FAIL read_data[%0d]: got %h required %h", i, buf_data_out, ed);
            end
        end
        buf_rddone = 1'b1;
        @(negedge clk);
        buf_rddone = 1'b0;
        if (check_cnt) begin
            checks++;
            if (n_wvf_in_buf !== n0 - 16'd1) begin
                errors++;
                $display("FAIL read_nwvf: got %0d required %0d", n_wvf_in_buf, n0 - 16'd1);
            end
            checks++;
            if (buf_wds_used !== u0 - 16'(2 * len)) begin
                errors++;
                $display("FAIL read_wds_used: got %0d required %0d", buf_wds_used, u0 - 16'(2 * len));
            end
        end
    endtask

    task automatic test_reset();
        assert_reset();
        checks++;
        if (buf_hdr_empty !== 1'b1 || n_wvf_in_buf !== 16'd0 || buf_wds_used !== 16'd0 || buf_data_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: empty=%b n=%0d used=%0d data=%h required 1/0/0/0",
                     buf_hdr_empty, n_wvf_in_buf, buf_wds_used, buf_data_out);
        end
        checks++;
        if ((wvb_hdr_rdreq | wvb_rdreq | wvb_rddone) !== '0) begin
            errors++;
            $display("FAIL reset_strobes: got %h required 0", wvb_hdr_rdreq | wvb_rdreq | wvb_rddone);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_en_gate();
        load_wvf(0, 3);
        load_wvf(0, 5);
        clear_counts();
        repeat (60) @(negedge clk);
        checks++;
        if (strobes_except(-1, -1) !== 0) begin
            errors++;
            $display("FAIL en_gate_strobes: got %0d required 0", strobes_except(-1, -1));
        end
        checks++;
        if (n_wvf_in_buf !== 16'd0 || buf_hdr_empty !== 1'b1) begin
            errors++;
            $display("FAIL en_gate_state: n=%0d empty=%b required 0/1", n_wvf_in_buf, buf_hdr_empty);
        end
    endtask

    task automatic test_drain();
        en = 1'b1;
        wait_nwvf(2, 2000);
        repeat (30) @(negedge clk);
        checks++;
        if (hdr_cnt[0] !== 2 || done_cnt[0] !== 2 || rd_cnt[0] !== 8) begin
            errors++;
            $display("FAIL drain_ch0_strobes: hdr=%0d done=%0d rd=%0d required 2/2/8", hdr_cnt[0], done_cnt[0], rd_cnt[0]);
        end
        checks++;
        if (strobes_except(0, 0) !== 0) begin
            errors++;
            $display("FAIL drain_other_strobes: got %0d required 0", strobes_except(0, 0));
        end
        checks++;
        if (n_wvf_in_buf !== 16'd2 || buf_wds_used !== 16'd16) begin
            errors++;
            $display("FAIL drain_counts: n=%0d used=%0d required 2/16", n_wvf_in_buf, buf_wds_used);
        end
    endtask

    task automatic test_read();
        en = 1'b0;
        read_wvf(1'b1);
        read_wvf(1'b1);
        checks++;
        if (buf_hdr_empty !== 1'b1 || buf_wds_used !== 16'd0 || n_wvf_in_buf !== 16'd0) begin
            errors++;
            $display("FAIL read_all_drained: empty=%b used=%0d n=%0d required 1/0/0",
                     buf_hdr_empty, buf_wds_used, n_wvf_in_buf);
        end
    endtask

    task automatic test_ignore();
        logic [HALF-1:0] prev;
        @(negedge clk);
        prev = buf_data_out;
        buf_rdreq = 1'b1; buf_hdr_rdreq = 1'b1; buf_rddone = 1'b1;
        @(negedge clk);
        buf_rdreq = 1'b0; buf_hdr_rdreq = 1'b0; buf_rddone = 1'b0;
        @(negedge clk);
        checks++;
        if (buf_wds_used !== 16'd0 || n_wvf_in_buf !== 16'd0 || buf_hdr_empty !== 1'b1) begin
            errors++;
            $display("FAIL ignore_counts: used=%0d n=%0d empty=%b required 0/0/1",
                     buf_wds_used, n_wvf_in_buf, buf_hdr_empty);
        end
        checks++;
        if (buf_data_out !== prev) begin
            errors++;
            $display("FAIL ignore_data: got %h required %h", buf_data_out, prev);
        end
    endtask

    task automatic test_multi();
        assert_reset();
        load_wvf(0, 4);
        load_wvf(5, 6);
        clear_counts();
        en = 1'b1;
        rst_n = 1'b1;
        wait_nwvf(2, 2000);
        checks++;
        if (done_order.size() != 2) begin
            errors++;
            $display("FAIL multi_order_len: got %0d required 2", done_order.size());
        end else begin
            checks++;
            if (done_order[0] !== 0 || done_order[1] !== 5) begin
                errors++;
                $display("FAIL multi_order: got %0d,%0d required 0,5", done_order[0], done_order[1]);
            end
        end
        checks++;
        if (strobes_except(0, 5) !== 0 || buf_wds_used !== 16'd20) begin
            errors++;
            $display("FAIL multi_counts: stray=%0d used=%0d required 0/20", strobes_except(0, 5), buf_wds_used);
        end
        read_wvf(1'b1);
        read_wvf(1'b1);
    endtask

    task automatic test_back_to_back();
        load_wvf(0, 10);
        wait_nwvf(1, 2000);
        load_wvf(5, 10);
        read_wvf(1'b0);
        wait_nwvf(1, 2000);
        repeat (5) @(negedge clk);
        checks++;
        if (buf_wds_used !== 16'd20 || n_wvf_in_buf !== 16'd1) begin
            errors++;
            $display("FAIL b2b_counts: used=%0d n=%0d required 20/1", buf_wds_used, n_wvf_in_buf);
        end
        read_wvf(1'b1);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        int d0;
        clear_counts();
        load_wvf(0, 40);
        en = 1'b1;
        while (rd_cnt[0] < 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (rd_cnt[0] < 3 || buf_wds_used === 16'd0) begin
            errors++;
            $display("FAIL reset_mid_precond: rd=%0d used=%0d required >=3 and >0", rd_cnt[0], buf_wds_used);
        end
        d0 = done_cnt[0];
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (buf_hdr_empty !== 1'b1 || n_wvf_in_buf !== 16'd0 || buf_wds_used !== 16'd0 || buf_data_out !== '0 ||
            (wvb_hdr_rdreq | wvb_rdreq | wvb_rddone) !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: empty=%b n=%0d used=%0d data=%h strobes=%h required 1/0/0/0/0",
                     buf_hdr_empty, n_wvf_in_buf, buf_wds_used, buf_data_out, wvb_hdr_rdreq | wvb_rdreq | wvb_rddone);
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        hq0.delete(); dq0.delete(); exp_hdr.delete(); exp_data.delete(); exp_len.delete();
        refresh();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt[0] !== d0 || n_wvf_in_buf !== 16'd0 || buf_wds_used !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_discard: done=%0d n=%0d used=%0d required %0d/0/0",
                     done_cnt[0], n_wvf_in_buf, buf_wds_used, d0);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_en_gate();
        test_drain();
        test_read();
        test_ignore();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
